conv_window_mac: RTL

Pipelined multiply-accumulate stage directly downstream of the line-buffer window generator. Each valid KER_SIZE×KER_SIZE×NFMAPS window is multiplied element-wise with a stored kernel. The products are summed, with bias added, into one output activation per window. Kernel and bias are loaded serially through a small load FSM.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_fmap_dot.sv | 48 ++++
 rtl/conv_window_mac.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv_window_mac datapath.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    // Accumulator width: full product, per-tap growth, plus one sign-safety bit.
    function automatic int calc_accw(input int bitwidth, input int ntaps);
        return 2 * bitwidth + 1 + $clog2(ntaps) + 1;
    endfunction

    function automatic int tap_idx(input int f, input int r, input int c, input int k);
        return f * k * k + r * k + c;
    endfunction

endpackage

// File: rtl/conv_fmap_dot.sv
// One feature map's K*K dot product: S1 registers the products, S2 registers their sum.
module conv_fmap_dot
    import conv_pkg::*;
#(
    parameter int KER_SIZE = 3,
    parameter int BITWIDTH = 8,
    parameter int ACCW     = 23
) (
    input  logic                                  clk,
    input  logic [KER_SIZE*KER_SIZE*BITWIDTH-1:0] pix,
    input  logic [KER_SIZE*KER_SIZE*BITWIDTH-1:0] wts,
    output logic [ACCW-1:0]                       sum
);

    localparam int KK = KER_SIZE * KER_SIZE;
    localparam int PW = 2 * BITWIDTH + 1;

    logic signed [PW-1:0]   prod_d [KK];
    logic signed [PW-1:0]   prod_q [KK];
    logic signed [ACCW-1:0] sum_d;
    logic signed [ACCW-1:0] sum_q;

    // Pixels are unsigned: a zero MSB makes them non-negative signed operands.
    always_comb begin
        for (int unsigned r = 0; r < KER_SIZE; r++) begin
            for (int unsigned c = 0; c < KER_SIZE; c++) begin
                prod_d[tap_idx(0, int'(r), int'(c), KER_SIZE)] =
                    $signed({1'b0, pix[tap_idx(0, int'(r), int'(c), KER_SIZE)*BITWIDTH +: BITWIDTH]}) *
                    $signed(wts[tap_idx(0, int'(r), int'(c), KER_SIZE)*BITWIDTH +: BITWIDTH]);
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < KK; i++) begin
            sum_d = sum_d + ACCW'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        sum_q  <= sum_d;
    end

    assign sum = sum_q;

endmodule

// File: rtl/conv_window_mac.sv
// Window x kernel MAC with serial kernel/bias load; 3-cycle pipeline.
// Define CONV_WINDOW_MAC_RELU_EN to clamp negative results to zero.
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int KER_SIZE = 3,
    parameter int BITWIDTH = 8,
    parameter int NFMAPS   = 3,
    localparam int NTAPS   = NFMAPS * KER_SIZE * KER_SIZE,
    localparam int ACCW    = calc_accw(BITWIDTH, NTAPS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      win_valid,
    input  logic [NTAPS*BITWIDTH-1:0] win,
    input  logic                      w_load,
    input  logic                      w_valid,
    input  logic [BITWIDTH-1:0]       w_data,
    input  logic [ACCW-1:0]           bias,
    output logic                      w_ready,
    output logic                      kernel_ok,
    output logic                      out_valid,
    output logic [ACCW-1:0]           out_data,
    output logic                      win_dropped
);

    localparam int KK    = KER_SIZE * KER_SIZE;
    localparam int WIDXW = $clog2(NTAPS);

    state_t                state_q, state_d;
    logic [WIDXW-1:0]      widx_q, widx_d;
    logic [BITWIDTH-1:0]   w_q [NTAPS];
    logic [BITWIDTH-1:0]   w_d [NTAPS];
    logic [ACCW-1:0]       bias_q, bias_d;
    logic                  dropped_q, dropped_d;
    logic                  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [ACCW-1:0]       out_data_q, out_data_d;
    logic                  w_ready_q, w_ready_d;
    logic                  kernel_ok_q, kernel_ok_d;
    logic                  flush;
    logic [NTAPS*BITWIDTH-1:0] wvec;
    logic signed [ACCW-1:0] fsum [NFMAPS];
    logic signed [ACCW-1:0] acc;

    always_comb begin
        for (int unsigned n = 0; n < NTAPS; n++) begin
            wvec[n*BITWIDTH +: BITWIDTH] = w_q[n];
        end
    end

    for (genvar f = 0; f < NFMAPS; f++) begin : g_fmap
        conv_fmap_dot #(
            .KER_SIZE (KER_SIZE),
            .BITWIDTH (BITWIDTH),
            .ACCW     (ACCW)
        ) u_dot (
            .clk (clk),
            .pix (win[tap_idx(f, 0, 0, KER_SIZE)*BITWIDTH +: KK*BITWIDTH]),
            .wts (wvec[tap_idx(f, 0, 0, KER_SIZE)*BITWIDTH +: KK*BITWIDTH]),
            .sum (fsum[f])
        );
    end

    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        w_d       = w_q;
        bias_d    = bias_q;
        dropped_d = dropped_q;
        flush     = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_load) begin
                    state_d = LOAD;
                    widx_d  = '0;
                end
            end
            LOAD: begin
                if (w_load) begin
                    widx_d = '0;
                end else if (w_valid) begin
                    w_d[widx_q] = w_data;
                    if (widx_q == WIDXW'(NTAPS - 1)) begin
                        bias_d  = bias;
                        widx_d  = '0;
                        state_d = RUN;
                    end else begin
                        widx_d = widx_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_load) begin
                    state_d = LOAD;
                    widx_d  = '0;
                    flush   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_load) dropped_d = 1'b0;
        if (win_valid && state_q != RUN) dropped_d = 1'b1;

        v1_d = win_valid && state_q == RUN && !flush;
        v2_d = v1_q && !flush;
        v3_d = v2_q && !flush;

        w_ready_d   = state_d == LOAD;
        kernel_ok_d = state_d == RUN;
    end

    // S3: cross-fmap reduction plus bias; out_data only updates with a valid result.
    always_comb begin
        acc = $signed(bias_q);
        for (int unsigned f = 0; f < NFMAPS; f++) begin
            acc = acc + fsum[f];
        end
`ifdef CONV_WINDOW_MAC_RELU_EN
        if (acc[ACCW-1]) acc = '0;
`endif
        out_data_d = v3_d ? acc : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            widx_q      <= '0;
            w_q         <= '{default: '0};
            bias_q      <= '0;
            dropped_q   <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_data_q  <= '0;
            w_ready_q   <= 1'b0;
            kernel_ok_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            w_q         <= w_d;
            bias_q      <= bias_d;
            dropped_q   <= dropped_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            v3_q        <= v3_d;
            out_data_q  <= out_data_d;
            w_ready_q   <= w_ready_d;
            kernel_ok_q <= kernel_ok_d;
        end
    end

    assign w_ready     = w_ready_q;
    assign kernel_ok   = kernel_ok_q;
    assign out_valid   = v3_q;
    assign out_data    = out_data_q;
    assign win_dropped = dropped_q;

endmodule
